// File: rtl/mem_arb.sv
// Three-way single-port RAM arbiter (loader write, FPU write-back, operand fetch), fixed or round-robin.
// Grants are combinational; RAM command is registered; fetch data returns 3 cycles after grant. Losers simply wait.
module mem_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              ma_clk,
  input  logic              ma_reset,
  input  logic              ma_fixed_prio,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic              ld_gnt,
  output logic              wb_gnt,
  output logic              fe_gnt,
  output logic              fe_rvalid,
  output logic [DATA_W-1:0] fe_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              ma_idle
);

  // Ring order is LD -> FE -> WB -> LD; last_q names the most recent winner.
  localparam logic [1:0] P_LD = 2'd0;
  localparam logic [1:0] P_FE = 2'd1;
  localparam logic [1:0] P_WB = 2'd2;

  logic [1:0] last_q;
  logic [1:0] rd_tag_q;

  always_comb begin
    ld_gnt = 1'b0;
    wb_gnt = 1'b0;
    fe_gnt = 1'b0;
    if (!ma_reset) begin
      if (ma_fixed_prio) begin
        if (ld_req)      ld_gnt = 1'b1;
        else if (wb_req) wb_gnt = 1'b1;
        else if (fe_req) fe_gnt = 1'b1;
      end else begin
        case (last_q)
          P_LD: begin
            if (fe_req)      fe_gnt = 1'b1;
            else if (wb_req) wb_gnt = 1'b1;
            else if (ld_req) ld_gnt = 1'b1;
          end
          P_FE: begin
            if (wb_req)      wb_gnt = 1'b1;
            else if (ld_req) ld_gnt = 1'b1;
            else if (fe_req) fe_gnt = 1'b1;
          end
          default: begin
            if (ld_req)      ld_gnt = 1'b1;
            else if (fe_req) fe_gnt = 1'b1;
            else if (wb_req) wb_gnt = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge ma_clk) begin
    if (ma_reset) begin
      last_q      <= P_WB;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      rd_tag_q    <= 2'b00;
      fe_rvalid   <= 1'b0;
      fe_rdata    <= '0;
    end else begin
      mem_we <= ld_gnt | wb_gnt;
      if (ld_gnt) begin
        mem_address <= ld_addr;
        mem_data_in <= ld_wdata;
        last_q      <= P_LD;
      end else if (wb_gnt) begin
        mem_address <= wb_addr;
        mem_data_in <= wb_wdata;
        last_q      <= P_WB;
      end else if (fe_gnt) begin
        mem_address <= fe_addr;
        last_q      <= P_FE;
      end
      // Tag stage 0: address on RAM port; stage 1: RAM data valid; then capture.
      rd_tag_q  <= {rd_tag_q[0], fe_gnt};
      fe_rvalid <= rd_tag_q[1];
      if (rd_tag_q[1]) fe_rdata <= mem_data_out;
    end
  end

  assign ma_idle = !(ld_req | wb_req | fe_req) && (rd_tag_q == 2'b00) && !fe_rvalid;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural synchronous RAM on the memory port.
module tb_mem_arb;

  logic        ma_clk = 1'b0;
  logic        ma_reset, ma_fixed_prio;
  logic        ld_req, wb_req, fe_req;
  logic [5:0]  ld_addr, wb_addr, fe_addr;
  logic [31:0] ld_wdata, wb_wdata;
  logic        ld_gnt, wb_gnt, fe_gnt;
  logic        fe_rvalid;
  logic [31:0] fe_rdata;
  logic [5:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;
  logic        ma_idle;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:63];
  logic [2:0]  gnt;
  logic [2:0]  rr_exp [0:2];

  assign gnt = {ld_gnt, fe_gnt, wb_gnt};

  always #5 ma_clk = ~ma_clk;

  always @(posedge ma_clk) begin
    if (mem_we) ram[mem_address] <= mem_data_in;
    mem_data_out <= ram[mem_address];
  end

  mem_arb #(.ADDR_W(6), .DATA_W(32)) dut (
    .ma_clk(ma_clk), .ma_reset(ma_reset), .ma_fixed_prio(ma_fixed_prio),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .fe_req(fe_req), .fe_addr(fe_addr),
    .ld_gnt(ld_gnt), .wb_gnt(wb_gnt), .fe_gnt(fe_gnt),
    .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out), .ma_idle(ma_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge ma_clk);
    @(negedge ma_clk);
  endtask

  initial begin
    rr_exp[0] = 3'b100;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b001;
    ma_reset = 1'b1; ma_fixed_prio = 1'b0;
    ld_req = 1'b1; wb_req = 1'b1; fe_req = 1'b1;
    ld_addr = '0; wb_addr = '0; fe_addr = '0;
    ld_wdata = '0; wb_wdata = '0;

    // Reset: grants gated even with every request high
    @(negedge ma_clk);
    chk("rst_gnt_gated", gnt, 3'b000);
    cyc();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_din", mem_data_in, 0);
    chk("rst_rvalid", fe_rvalid, 0);
    chk("rst_rdata", fe_rdata, 0);

    // Single write then read of address 5; LD granted in first cycle out of reset
    ma_reset = 1'b0; wb_req = 1'b0; fe_req = 1'b0;
    ld_req = 1'b1; ld_addr = 6'd5; ld_wdata = 32'hDEADBEEF;
    #1 chk("first_gnt_ld", gnt, 3'b100);
    cyc();
    ld_req = 1'b0; fe_req = 1'b1; fe_addr = 6'd5;
    #1;
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_address, 5);
    chk("wr_data", mem_data_in, 32'hDEADBEEF);
    chk("rd_gnt_fe", gnt, 3'b010);
    cyc();
    fe_req = 1'b0;
    #1;
    chk("rd_we_low", mem_we, 0);
    chk("rd_addr", mem_address, 5);
    chk("rd_rvalid_n1", fe_rvalid, 0);
    cyc();
    chk("rd_rvalid_n2", fe_rvalid, 0);
    cyc();
    chk("rd_rvalid_n3", fe_rvalid, 1);
    chk("rd_rdata_n3", fe_rdata, 32'hDEADBEEF);
    cyc();
    chk("rd_rvalid_n4", fe_rvalid, 0);
    chk("rd_rdata_hold", fe_rdata, 32'hDEADBEEF);
    chk("idle_after_rd", ma_idle, 1);

    // Round-robin from a fresh reset: LD,FE,WB x3
    ma_reset = 1'b1;
    cyc();
    ma_reset = 1'b0; ma_fixed_prio = 1'b0;
    ld_req = 1'b1; fe_req = 1'b1; wb_req = 1'b1;
    ld_addr = 6'd10; wb_addr = 6'd11; fe_addr = 6'd12;
    ld_wdata = 32'h1111_0000; wb_wdata = 32'h2222_0000;
    for (int i = 0; i < 9; i++) begin
      #1 chk($sformatf("rr_%0d", i), gnt, rr_exp[i % 3]);
      cyc();
    end

    // Fixed priority: LD every cycle
    ma_fixed_prio = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("fix_ld_%0d", i), gnt, 3'b100);
      cyc();
    end
    // Mode change applies in the same cycle: after LD, round-robin picks FE
    ma_fixed_prio = 1'b0;
    #1 chk("mode_switch_rr_fe", gnt, 3'b010);
    cyc();
    ma_fixed_prio = 1'b1; ld_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("fix_wb_%0d", i), gnt, 3'b001);
      cyc();
    end
    wb_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("fix_fe_%0d", i), gnt, 3'b010);
      cyc();
    end
    fe_req = 1'b0;
    #1 chk("no_req_no_gnt", gnt, 3'b000);
    for (int i = 0; i < 4; i++) cyc();
    chk("idle_drained", ma_idle, 1);

    // Pipelined reads: preload 0x10..0x12 then three back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      ld_req = 1'b1; ld_addr = 6'(i); ld_wdata = 32'h10 + 32'(i);
      cyc();
    end
    ld_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fe_req = 1'b1; fe_addr = 6'(i);
      #1 chk($sformatf("pipe_gnt_%0d", i), fe_gnt, 1);
      cyc();
    end
    fe_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pipe_rvalid_%0d", i), fe_rvalid, 1);
      chk($sformatf("pipe_rdata_%0d", i), fe_rdata, 32'h10 + 32'(i));
      cyc();
    end
    chk("pipe_rvalid_end", fe_rvalid, 0);
    chk("pipe_rdata_hold", fe_rdata, 32'h12);

    // Reset while a read is in flight
    fe_req = 1'b1; fe_addr = 6'd1;
    #1 chk("rstrd_gnt", gnt, 3'b010);
    cyc();
    fe_req = 1'b0; ld_req = 1'b1; ma_reset = 1'b1;
    #1 chk("rstrd_gated", gnt, 3'b000);
    cyc();
    ld_req = 1'b0; ma_reset = 1'b0;
    #1;
    chk("rstrd_we", mem_we, 0);
    chk("rstrd_addr", mem_address, 0);
    chk("rstrd_din", mem_data_in, 0);
    chk("rstrd_rdata", fe_rdata, 0);
    chk("rstrd_idle", ma_idle, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstrd_rvalid_%0d", i), fe_rvalid, 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Parameters
REQ-001 ADDR_W, 6, memory address width.
REQ-002 DATA_W, 32, memory data width.

Interface
REQ-003 ma_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 ma_reset  in  1  reset, synchronous, active-high.
REQ-005 ma_fixed_prio  in  1  1 = fixed priority LD>WB>FE; 0 = round-robin.
REQ-006 ld_req / ld_addr / ld_wdata  in  1 / ADDR_W / DATA_W  loader write request (input data to RAM).
REQ-007 wb_req / wb_addr / wb_wdata  in  1 / ADDR_W / DATA_W  FPU result write-back request.
REQ-008 fe_req / fe_addr  in  1 / ADDR_W  operand fetch read request.
REQ-009 ld_gnt, wb_gnt, fe_gnt  out  1 each  combinational grant; transfer occurs on the edge where req and gnt are both high.
REQ-010 fe_rvalid / fe_rdata  out  1 / DATA_W  registered read return.
REQ-011 mem_address / mem_data_in / mem_we  out  ADDR_W / DATA_W / 1  registered single-port RAM command.
REQ-012 mem_data_out  in  DATA_W  synchronous RAM read data, valid one cycle after the address is presented.
REQ-013 ma_idle  out  1  high when no request is pending and no read is in flight.

Function
REQ-014 At most one grant SHALL be high in any cycle; a grant is never high without its request.
REQ-015 Round-robin: search order starts after the last granted requester in cycle LD->FE->WB->LD; pointer updates only on a granted transfer.
REQ-016 Fixed priority: LD over WB over FE; pointer still updates on each transfer.
REQ-017 On a granted edge: mem_address <= granted addr; mem_we <= 1 for LD/WB, 0 for FE; mem_data_in <= granted wdata for writes, held otherwise.
REQ-018 With no granted transfer: mem_we <= 0; mem_address and mem_data_in hold.
REQ-019 Requesters may keep req high across cycles; each cycle of req&gnt is one independent access (back-to-back same-requester grants are legal).
REQ-020 Read latency: FE granted in cycle N -> address on RAM port in N+1 -> mem_data_out valid in N+2 -> fe_rvalid=1 and fe_rdata registered in cycle N+3, for exactly one cycle per read.
REQ-021 A 2-stage read-tag shift register SHALL track in-flight reads; up to 3 reads may be outstanding, returned in grant order.
REQ-022 fe_rdata holds its last value when fe_rvalid=0.
REQ-023 Write then read of the same address in consecutive grants returns the newly written data (port order preserved; no bypass needed).
REQ-024 ma_fixed_prio change takes effect in the same cycle; no transfer lost or duplicated.
REQ-025 ma_idle = no req high and read-tag pipeline and fe_rvalid all clear.

Reset
REQ-026 While ma_reset=1: all grants 0 (combinationally gated), mem_we=0, mem_address=0, mem_data_in=0, fe_rvalid=0, fe_rdata=0, pointer=WB (LD wins first round-robin), read tags cleared.
REQ-027 Reset mid-operation discards in-flight reads; no fe_rvalid after reset deasserts for reads granted before reset.
REQ-028 First grant possible in the first cycle with ma_reset=0.

Verification
REQ-029 Single write/read: LD addr 5 data 0xDEADBEEF granted, then FE addr 5 -> mem_we pulse at addr 5, fe_rvalid 3 cycles after FE grant with fe_rdata=0xDEADBEEF.
REQ-030 Round-robin fairness: ld/fe/wb_req held high 9 cycles, ma_fixed_prio=0 -> grant sequence LD,FE,WB repeated 3 times, exactly one grant per cycle.
REQ-031 Fixed priority: all three held high, ma_fixed_prio=1 -> LD every cycle; drop ld_req -> WB every cycle; FE only when LD and WB idle.
REQ-032 Pipelined reads: FE addrs 0,1,2 granted back-to-back (RAM preloaded 0x10,0x11,0x12) -> fe_rvalid high 3 consecutive cycles with 0x10,0x11,0x12 in order.
REQ-033 Reset mid-read: FE granted, ma_reset pulsed next cycle -> fe_rvalid stays 0, all outputs at reset values, ma_idle=1 after reset with no requests.
